// File: rtl/irq_exc_ctrl_pkg.sv
// Shared definitions for the interrupt/exception sequencer.
//   - FSM state encoding (IDLE / HANDLER / RESUME)
//   - config register addresses and STATUS bit positions
//   - CAUSE interrupt flag bit
//   - handler vector, used by the PC register and the bench
package irq_exc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HANDLER = 2'd1,
    ST_RESUME  = 2'd2
  } state_e;

  localparam logic [1:0] CFG_MASK   = 2'd0;
  localparam logic [1:0] CFG_STATUS = 2'd1;
  localparam logic [1:0] CFG_CAUSE  = 2'd2;
  localparam logic [1:0] CFG_SEPC   = 2'd3;

  localparam int STATUS_IE_BIT      = 0;
  localparam int STATUS_DF_BIT      = 1;
  localparam int STATUS_HANDLER_BIT = 2;
  localparam int STATUS_PEND_LSB    = 8;

  localparam int CAUSE_INT_BIT = 7;

  // Width of an interrupt index; enough for up to 8 lines.
  localparam int IDX_W = 3;

  localparam logic [31:0] HANDLER_VEC = 32'h0000_00cc;

endpackage

// File: rtl/irq_exc_ctrl_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder.
// Ports:
//   req   in  N      request vector
//   valid out 1      any request set
//   idx   out IDX_W  index of the lowest set request (0 when none)
module irq_prio_enc
  import irq_exc_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the last hit is the lowest index.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/irq_exc_ctrl.sv
// irq_exc_ctrl: interrupt/exception sequencer beside the PC register.
// Latches rising edges on irq into PEND, masks them and, at instruction
// boundaries (pc_write), decides whether the PC is redirected to
// HANDLER_VEC (int_signal). Captures SEPC/CAUSE, tracks ERET/ERETN and
// re-enables interrupts after a one-boundary holdoff.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   irq             rising-edge sensitive interrupt lines
//   pc_write        instruction boundary
//   pc, npc         committing address / next address
//   exc_req         synchronous exception, exc_code its code
//   eret, eretn     return instructions committing
//   cfg_we/addr/wdata, cfg_rdata   CPU config port (read is combinational)
//   int_signal      single-cycle redirect request (combinational)
//   sepc            saved exception PC
//   state_dbg       current FSM state
// Handshake: there is no valid/ready pair here; every input is qualified
// by pc_write (boundary) or cfg_we (config write) and acts in that cycle.
module irq_exc_ctrl
  import irq_exc_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               pc_write,
  input  logic [31:0]        pc,
  input  logic [31:0]        npc,
  input  logic               exc_req,
  input  logic [3:0]         exc_code,
  input  logic               eret,
  input  logic               eretn,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               int_signal,
  output logic [31:0]        sepc,
  output state_e             state_dbg
);

  state_e             state_q, state_n;
  logic               ie_q, df_q;
  logic [NUM_IRQ-1:0] mask_q, pend_q, irq_q;
  logic [7:0]         cause_q;
  logic [31:0]        sepc_q;

  logic [NUM_IRQ-1:0] ready, irq_rise, take_clr, pend_w1c;
  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;

  logic               sepc_ld, cause_ld, ie_clr, ie_set, df_set, take_irq;
  logic [31:0]        sepc_val;
  logic [7:0]         cause_val;

  logic               mask_we, status_we, sepc_we;
  logic               unused_cfg_bits;

  assign irq_rise  = irq & ~irq_q;
  assign ready     = pend_q & mask_q;

  assign mask_we   = cfg_we && (cfg_addr == CFG_MASK);
  assign status_we = cfg_we && (cfg_addr == CFG_STATUS);
  assign sepc_we   = cfg_we && (cfg_addr == CFG_SEPC);
  assign pend_w1c  = status_we ? cfg_wdata[STATUS_PEND_LSB +: NUM_IRQ] : '0;
  assign unused_cfg_bits = ^cfg_wdata;

  irq_prio_enc #(.N(NUM_IRQ)) u_prio (
    .req   (ready),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // Next state and the single-cycle redirect decision.
  always_comb begin
    state_n    = state_q;
    int_signal = 1'b0;
    sepc_ld    = 1'b0;
    sepc_val   = pc;
    cause_ld   = 1'b0;
    cause_val  = '0;
    ie_clr     = 1'b0;
    ie_set     = 1'b0;
    df_set     = 1'b0;
    take_irq   = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESUME: begin
        if (pc_write) begin
          if (exc_req) begin
            // Exceptions are taken regardless of IE and beat any irq.
            int_signal = 1'b1;
            sepc_ld    = 1'b1;
            sepc_val   = pc;
            cause_ld   = 1'b1;
            cause_val  = {4'b0000, exc_code};
            ie_clr     = 1'b1;
            state_n    = ST_HANDLER;
          end else if ((state_q == ST_IDLE) && ie_q && win_valid && !eret && !eretn) begin
            // Interrupt returns to the instruction the PC was about to load.
            int_signal = 1'b1;
            take_irq   = 1'b1;
            sepc_ld    = 1'b1;
            sepc_val   = npc;
            cause_ld   = 1'b1;
            cause_val  = {1'b1, 3'b000, 1'b0, win_idx};
            ie_clr     = 1'b1;
            state_n    = ST_HANDLER;
          end else if (state_q == ST_RESUME) begin
            // One instruction of forward progress before interrupts return.
            state_n = ST_IDLE;
          end
        end
      end
      ST_HANDLER: begin
        if (pc_write) begin
          if (eret || eretn) begin
            ie_set  = 1'b1;
            state_n = ST_RESUME;
          end else if (exc_req) begin
            // Double fault: redirect again but keep the original context.
            int_signal = 1'b1;
            df_set     = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++) begin
      take_clr[i] = take_irq && (win_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    // irq_q keeps sampling through reset so a line held high across
    // reset is not seen as a fresh edge afterwards.
    irq_q <= irq;
    if (rst) begin
      state_q <= ST_IDLE;
      ie_q    <= 1'b0;
      df_q    <= 1'b0;
      mask_q  <= '0;
      pend_q  <= '0;
      cause_q <= '0;
      sepc_q  <= '0;
    end else begin
      state_q <= state_n;
      if (mask_we) mask_q <= cfg_wdata[NUM_IRQ-1:0];
      // New edges win over same-cycle clears.
      pend_q <= (pend_q & ~(take_clr | pend_w1c)) | irq_rise;
      // Hardware updates override config writes.
      if (ie_clr)         ie_q <= 1'b0;
      else if (ie_set)    ie_q <= 1'b1;
      else if (status_we) ie_q <= cfg_wdata[STATUS_IE_BIT];
      if (df_set)                                   df_q <= 1'b1;
      else if (status_we && cfg_wdata[STATUS_DF_BIT]) df_q <= 1'b0;
      if (cause_ld) cause_q <= cause_val;
      if (sepc_ld)      sepc_q <= sepc_val;
      else if (sepc_we) sepc_q <= cfg_wdata;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      CFG_MASK:   cfg_rdata[NUM_IRQ-1:0] = mask_q;
      CFG_STATUS: begin
        cfg_rdata[STATUS_IE_BIT]      = ie_q;
        cfg_rdata[STATUS_DF_BIT]      = df_q;
        cfg_rdata[STATUS_HANDLER_BIT] = (state_q == ST_HANDLER);
        cfg_rdata[STATUS_PEND_LSB +: NUM_IRQ] = pend_q;
      end
      CFG_CAUSE:  cfg_rdata[7:0] = cause_q;
      default:    cfg_rdata = sepc_q;
    endcase
  end

  assign sepc      = sepc_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_irq_exc_ctrl.sv
module tb_irq_exc_ctrl;
  import irq_exc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq;
  logic        pc_write;
  logic [31:0] pc, npc;
  logic        exc_req;
  logic [3:0]  exc_code;
  logic        eret, eretn;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        int_signal;
  logic [31:0] sepc;
  state_e      state_dbg;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  irq_exc_ctrl #(.NUM_IRQ(4)) dut (
    .clk(clk), .rst(rst), .irq(irq), .pc_write(pc_write), .pc(pc), .npc(npc),
    .exc_req(exc_req), .exc_code(exc_code), .eret(eret), .eretn(eretn),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .int_signal(int_signal), .sepc(sepc),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    pc_write = 1'b0; exc_req = 1'b0; exc_code = 4'd0;
    eret = 1'b0; eretn = 1'b0; cfg_we = 1'b0; cfg_wdata = '0;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0; cfg_wdata = '0;
  endtask

  task automatic rd_cfg(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic boundary(input logic [31:0] p, input logic [31:0] n);
    pc_write = 1'b1; pc = p; npc = n;
    #1;
  endtask

  task automatic pulse_irq(input logic [3:0] v);
    irq = v; tick();
    irq = 4'b0000; tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; irq = '0; pc = '0; npc = '0; cfg_addr = '0;
    clear_inputs();
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (int_signal !== 1'b0) begin errors++; $display("FAIL reset_int: got %b expected 0", int_signal); end
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE); end
    for (int a = 0; a < 4; a++) begin
      rd_cfg(2'(a), rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_reg%0d: got %h expected 0", a, rd); end
    end
  endtask

  task automatic test_irq_take();
    cfg_write(CFG_MASK, 32'hF);
    cfg_write(CFG_STATUS, 32'h1);
    pulse_irq(4'b0100);
    pulse_irq(4'b0010);
    rd_cfg(CFG_STATUS, rd);
    checks++; if (rd !== 32'h601) begin errors++; $display("FAIL pend_latch: got %h expected 601", rd); end
    boundary(32'h3c, 32'h40);
    checks++; if (int_signal !== 1'b1) begin errors++; $display("FAIL irq_take_int: got %b expected 1", int_signal); end
    tick(); clear_inputs();
    checks++; if (sepc !== 32'h40) begin errors++; $display("FAIL irq_take_sepc: got %h expected 40", sepc); end
    rd_cfg(CFG_CAUSE, rd);
    checks++; if (rd !== 32'h81) begin errors++; $display("FAIL irq_take_cause: got %h expected 81", rd); end
    rd_cfg(CFG_STATUS, rd);
    checks++; if (rd !== 32'h404) begin errors++; $display("FAIL irq_take_status: got %h expected 404", rd); end
  endtask

  task automatic test_handler_resume();
    pulse_irq(4'b0001);
    for (int i = 0; i < 3; i++) begin
      boundary(32'hcc + 32'(4 * i), 32'hd0 + 32'(4 * i));
      checks++; if (int_signal !== 1'b0) begin errors++; $display("FAIL handler_no_irq%0d: got %b expected 0", i, int_signal); end
      tick(); clear_inputs();
    end
    eret = 1'b1; boundary(32'hd8, 32'h40);
    checks++; if (int_signal !== 1'b0) begin errors++; $display("FAIL eret_int: got %b expected 0", int_signal); end
    tick(); clear_inputs();
    checks++; if (state_dbg !== ST_RESUME) begin errors++; $display("FAIL eret_state: got %0d expected %0d", state_dbg, ST_RESUME); end
    rd_cfg(CFG_STATUS, rd);
    checks++; if (rd !== 32'h501) begin errors++; $display("FAIL eret_status: got %h expected 501", rd); end
    boundary(32'h40, 32'h44);
    checks++; if (int_signal !== 1'b0) begin errors++; $display("FAIL resume_holdoff: got %b expected 0", int_signal); end
    tick(); clear_inputs();
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL resume_to_idle: got %0d expected %0d", state_dbg, ST_IDLE); end
    boundary(32'h44, 32'h80);
    checks++; if (int_signal !== 1'b1) begin errors++; $display("FAIL resume_next_take: got %b expected 1", int_signal); end
    tick(); clear_inputs();
    rd_cfg(CFG_CAUSE, rd);
    checks++; if (rd !== 32'h80) begin errors++; $display("FAIL irq0_cause: got %h expected 80", rd); end
    rd_cfg(CFG_STATUS, rd);
    checks++; if (rd !== 32'h404) begin errors++; $display("FAIL irq0_status: got %h expected 404", rd); end
    // Return to IDLE, then disable interrupts and drop PEND[2].
    eret = 1'b1; boundary(32'hcc, 32'h80); tick(); clear_inputs();
    boundary(32'h80, 32'h84); tick(); clear_inputs();
    cfg_write(CFG_STATUS, 32'h400);
    rd_cfg(CFG_STATUS, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL w1c_pend: got %h expected 0", rd); end
  endtask

  task automatic test_exception();
    exc_req = 1'b1; exc_code = 4'd8; boundary(32'h100, 32'h104);
    checks++; if (int_signal !== 1'b1) begin errors++; $display("FAIL exc_int: got %b expected 1", int_signal); end
    tick(); clear_inputs();
    checks++; if (sepc !== 32'h100) begin errors++; $display("FAIL exc_sepc: got %h expected 100", sepc); end
    rd_cfg(CFG_CAUSE, rd);
    checks++; if (rd !== 32'h08) begin errors++; $display("FAIL exc_cause: got %h expected 08", rd); end
    eretn = 1'b1; boundary(32'hcc, 32'h104);
    checks++; if (int_signal !== 1'b0) begin errors++; $display("FAIL eretn_int: got %b expected 0", int_signal); end
    tick(); clear_inputs();
    checks++; if (state_dbg !== ST_RESUME) begin errors++; $display("FAIL eretn_state: got %0d expected %0d", state_dbg, ST_RESUME); end
    rd_cfg(CFG_STATUS, rd);
    checks++; if (rd !== 32'h001) begin errors++; $display("FAIL eretn_status: got %h expected 001", rd); end
    boundary(32'h104, 32'h108); tick(); clear_inputs();
  endtask

  task automatic test_exc_vs_irq_and_df();
    pulse_irq(4'b0010);
    rd_cfg(CFG_STATUS, rd);
    checks++; if (rd !== 32'h201) begin errors++; $display("FAIL wait_no_boundary: got %h expected 201", rd); end
    exc_req = 1'b1; exc_code = 4'd3; boundary(32'h200, 32'h204);
    checks++; if (int_signal !== 1'b1) begin errors++; $display("FAIL exc_irq_int: got %b expected 1", int_signal); end
    tick(); clear_inputs();
    rd_cfg(CFG_CAUSE, rd);
    checks++; if (rd !== 32'h03) begin errors++; $display("FAIL exc_wins_cause: got %h expected 03", rd); end
    rd_cfg(CFG_STATUS, rd);
    checks++; if (rd !== 32'h204) begin errors++; $display("FAIL exc_wins_pend: got %h expected 204", rd); end
    exc_req = 1'b1; exc_code = 4'd5; boundary(32'h300, 32'h304);
    checks++; if (int_signal !== 1'b1) begin errors++; $display("FAIL df_int: got %b expected 1", int_signal); end
    tick(); clear_inputs();
    rd_cfg(CFG_STATUS, rd);
    checks++; if (rd !== 32'h206) begin errors++; $display("FAIL df_status: got %h expected 206", rd); end
    checks++; if (sepc !== 32'h200) begin errors++; $display("FAIL df_sepc: got %h expected 200", sepc); end
    rd_cfg(CFG_CAUSE, rd);
    checks++; if (rd !== 32'h03) begin errors++; $display("FAIL df_cause: got %h expected 03", rd); end
    cfg_write(CFG_STATUS, 32'h2);
    rd_cfg(CFG_STATUS, rd);
    checks++; if (rd !== 32'h204) begin errors++; $display("FAIL df_clear: got %h expected 204", rd); end
  endtask

  task automatic test_reset_mid_handler();
    irq = 4'b1000; tick();
    rd_cfg(CFG_STATUS, rd);
    checks++; if (rd !== 32'hA04) begin errors++; $display("FAIL pre_reset_status: got %h expected a04", rd); end
    rst = 1'b1; tick(); rst = 1'b0;
    #1;
    checks++; if (int_signal !== 1'b0) begin errors++; $display("FAIL mid_reset_int: got %b expected 0", int_signal); end
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL mid_reset_state: got %0d expected %0d", state_dbg, ST_IDLE); end
    for (int a = 0; a < 4; a++) begin
      rd_cfg(2'(a), rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_reset_reg%0d: got %h expected 0", a, rd); end
    end
    tick(); tick();
    rd_cfg(CFG_STATUS, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL held_irq_no_edge: got %h expected 0", rd); end
    irq = 4'b0000; tick();
    pulse_irq(4'b1000);
    rd_cfg(CFG_STATUS, rd);
    checks++; if (rd !== 32'h800) begin errors++; $display("FAIL new_edge_after_reset: got %h expected 800", rd); end
  endtask

  task automatic test_back_to_back();
    cfg_write(CFG_STATUS, 32'h800);
    cfg_write(CFG_MASK, 32'hF);
    cfg_write(CFG_STATUS, 32'h1);
    irq = 4'b0100; boundary(32'h0c, 32'h10);
    checks++; if (int_signal !== 1'b0) begin errors++; $display("FAIL same_cycle_edge: got %b expected 0", int_signal); end
    tick();
    irq = 4'b0000; boundary(32'h40, 32'h44);
    checks++; if (int_signal !== 1'b1) begin errors++; $display("FAIL next_cycle_take: got %b expected 1", int_signal); end
    tick(); clear_inputs();
    rd_cfg(CFG_CAUSE, rd);
    checks++; if (rd !== 32'h82) begin errors++; $display("FAIL b2b_cause: got %h expected 82", rd); end
    checks++; if (sepc !== 32'h44) begin errors++; $display("FAIL b2b_sepc: got %h expected 44", sepc); end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    test_reset();
    test_irq_take();
    test_handler_resume();
    test_exception();
    test_exc_vs_irq_and_df();
    test_reset_mid_handler();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
